// File: rtl/pulse_generator.sv
// pulse_generator: programmable pulse train source with bounded/continuous count and graceful stop.
// Optional build macro PGEN_JITTER_EN adds LFSR jitter (0..7 cycles) to every LOW phase.
module pulse_generator #(
    parameter int PERIOD_W = 24,
    parameter int WIDTH_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH_W-1:0]  width,
    input  logic [3:0]          num,
    output logic                pulse,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [3:0]          emitted
);
    localparam int W = (PERIOD_W > WIDTH_W) ? PERIOD_W : WIDTH_W;
`ifdef PGEN_JITTER_EN
    localparam int CW = W + 1;
    localparam logic [15:0] SEED = 16'hACE1;
`else
    localparam int CW = W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_FIN} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_lo_load;
    logic [W-1:0]    r_hi_m1, r_lo_m1;
    logic [W-1:0]    w_per, w_wid, w_eff_per, w_eff_wid;
    logic [3:0]      r_rem, r_emitted;
    logic            r_cont, r_stop_req, r_pulse, r_busy, r_done, r_aborted;
    logic            w_accept, w_abort, w_cnt_zero;

    assign w_per      = W'(period);
    assign w_wid      = W'(width);
    assign w_eff_per  = (w_per < W'(2)) ? W'(2) : w_per;
    assign w_eff_wid  = (w_wid == '0) ? W'(1) : (w_wid >= w_eff_per) ? w_eff_per - W'(1) : w_wid;
    assign w_cnt_zero = (r_cnt == '0);

`ifdef PGEN_JITTER_EN
    logic [15:0] r_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign w_lo_load = CW'(r_lo_m1) + CW'(r_lfsr[2:0]);

    // The LFSR advances on every HIGH entry, including the first one at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= SEED;
        else if (w_accept)
            r_lfsr <= lfsr_step(SEED);
        else if (r_state == S_LOW && w_next == S_HIGH)
            r_lfsr <= lfsr_step(r_lfsr);
    end
`else
    assign w_lo_load = CW'(r_lo_m1);
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start && !stop;
                w_next   = w_accept ? S_HIGH : S_IDLE;
            end
            S_HIGH: begin
                w_abort = w_cnt_zero && (stop || r_stop_req);
                w_next  = !w_cnt_zero ? S_HIGH : w_abort ? S_FIN : S_LOW;
            end
            S_LOW: begin
                w_abort = stop;
                w_next  = stop ? S_FIN : !w_cnt_zero ? S_LOW : (!r_cont && r_rem == 4'd0) ? S_FIN : S_HIGH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi_m1    <= '0;
            r_lo_m1    <= '0;
            r_rem      <= '0;
            r_cont     <= 1'b0;
            r_stop_req <= 1'b0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_emitted  <= '0;
        end else begin
            r_state <= w_next;
            r_pulse <= (r_state == S_HIGH);
            r_done  <= (r_state == S_FIN);
            r_busy  <= (w_next == S_HIGH) || (w_next == S_LOW);
            if (r_state == S_HIGH && !r_pulse)
                r_emitted <= r_emitted + 4'd1;
            if (w_abort)
                r_aborted <= 1'b1;
            // A stop seen mid-HIGH is remembered so the pulse still completes at full width.
            if (r_state == S_HIGH && stop)
                r_stop_req <= 1'b1;
            if (r_state == S_HIGH && w_next == S_LOW)
                r_cnt <= w_lo_load;
            else if (r_state == S_LOW && w_next == S_HIGH) begin
                r_cnt <= CW'(r_hi_m1);
                r_rem <= r_rem - 4'd1;
            end else if (!w_cnt_zero)
                r_cnt <= r_cnt - CW'(1);
            if (w_accept) begin
                r_hi_m1    <= w_eff_wid - W'(1);
                r_lo_m1    <= w_eff_per - w_eff_wid - W'(1);
                r_cnt      <= CW'(w_eff_wid - W'(1));
                r_rem      <= num - 4'd1;
                r_cont     <= (num == 4'd0);
                r_stop_req <= 1'b0;
                r_aborted  <= 1'b0;
                r_emitted  <= '0;
            end
        end
    end

    assign pulse   = r_pulse;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign emitted = r_emitted;
endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
Programmable pulse train source: the transmit-side counterpart of the pulse counter.
- Emits a fixed or bounded number of pulses with a programmed period and high width.
- Drives the counter's enable input during self-test, and serves as the synthetic heartbeat/pulse source for bench and on-board demo modes.
- Reports how many pulses it has emitted, on the same 4-bit wrap scheme the counter uses.

Parameters:
PERIOD_W, 24, width of period field in clk cycles
WIDTH_W, 16, width of high-time field in clk cycles

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to begin a train; sampled only in IDLE
stop  in  1  request to end the current train gracefully
period  in  PERIOD_W  pulse period in clk cycles; latched on accepted start
width  in  WIDTH_W  pulse high time in clk cycles; latched on accepted start
num  in  4  pulses to emit; 0 = continuous until stop
pulse  out  1  registered pulse output
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle strobe on return to IDLE
aborted  out  1  valid with done; 1 = ended by stop, 0 = num reached
emitted  out  4  rising edges of pulse since last accepted start; wraps 15->0

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk; one clock domain.
- Reset state: state=IDLE; pulse, busy, done, aborted, emitted all 0; shadow registers 0.
- States: IDLE, HIGH, LOW, FIN.
- Start acceptance:
  - start is accepted at edge k only in IDLE with stop=0.
  - On acceptance: period, width and num are latched; emitted<=0; busy<=1; state<=HIGH.
  - pulse=1 from edge k+1 (1-cycle latency).
- Operand sanitising (applied at latch):
  - eff_period = max(period,2).
  - eff_width = width clamped to [1, eff_period-1].
- HIGH:
  - pulse=1 for exactly eff_width cycles.
  - emitted increments on entry (modulo 16).
  - Then state goes to LOW.
- LOW:
  - pulse=0 for eff_period-eff_width cycles, giving a total period of exactly eff_period.
  - At the end of LOW:
    - If num!=0 and pulses emitted in this train = num, go to FIN.
    - Otherwise go to HIGH.
  - The terminal check uses an internal 4-bit remaining counter, not emitted.
- stop handling:
  - In HIGH: the current high phase completes at full width; pulse then drops and the state goes to FIN. No truncated pulses.
  - In LOW: go to FIN on the next edge.
  - In both cases aborted<=1.
- FIN: one cycle with busy=0, done=1, pulse=0; then IDLE. aborted holds its value until the next accepted start.
- emitted holds its final value in IDLE until the next accepted start.
- Collisions and changes in flight:
  - start while busy or in FIN is ignored.
  - start and stop together in IDLE: stop wins, nothing happens.
  - period, width and num changes while busy have no effect.
- Reset mid-train: pulse drops asynchronously on rst_n low; all outputs return to reset values.
- Counters:
  - Phase counter is max(PERIOD_W,WIDTH_W) bits and loads the phase length minus 1.
  - No arithmetic overflow is possible after sanitising.

Optional Feature:
Macro: PGEN_JITTER_EN
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset and on each accepted start) steps once per HIGH entry.
  - Its low 3 bits (0..7) are added to the LOW phase length, emulating heart-rate variability.
  - Effective period = eff_period + lfsr[2:0].
  - The HIGH width is unchanged.
- When undefined: no LFSR is present; the period is exact; the logic is removed entirely.
- Ports are identical in both builds.

Test Plan:
1. Reset then start: rst_n low 3 cycles, then pulse start with period=10, width=3, num=4 -> pulse high cycles 1-3, 11-13, 21-23, 31-33 after acceptance; done at cycle 41 with aborted=0; emitted=4; busy low from cycle 40.
2. Continuous + stop: period=6, width=2, num=0, stop asserted during second HIGH -> that high lasts full 2 cycles, then FIN; done=1, aborted=1, emitted=2.
3. Sanitising: period=1, width=0 -> eff 2/1, pulse toggles every cycle; separately period=5, width=9 -> high 4, low 1.
4. Collisions: start+stop together in IDLE -> busy stays 0; start during busy -> no restart, emitted continues.
5. Wrap + async reset: num=0, period=4, width=1, run 17 pulses -> emitted reads 1 after wrap; drop rst_n mid-HIGH -> pulse=0 immediately, all outputs 0.
6. PGEN_JITTER_EN build: period=10, width=3, num=3 -> each period in [10,17], sequence matches LFSR model seeded 16'hACE1; high width always 3.
